// File: rtl/occ_arbiter_pkg.sv
// Shared definitions for the Occ memory arbiter: FSM encoding, default widths
// and the timeout counter helper.
package occ_arbiter_pkg;

  localparam int unsigned OCC_ADDR_W  = 8;
  localparam int unsigned OCC_DATA_W  = 32;
  localparam int unsigned OCC_TIMEOUT = 16;
  localparam int unsigned OCC_CNT_W   = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } occ_state_e;

  function automatic logic [OCC_CNT_W-1:0] cnt_inc(input logic [OCC_CNT_W-1:0] cnt);
    return cnt + 8'd1;
  endfunction

endpackage

// File: rtl/occ_arbiter_rr_pick2.sv
// Two-way round-robin selector: on contention the requester not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic win
);

  // pick a winner from the current request pair
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

endmodule

// File: rtl/occ_arbiter.sv
// Arbitrates two requesters onto a single Occ ROM port, one outstanding read
// at a time, with a per-transaction timeout that returns an error response.
module occ_arbiter
  import occ_arbiter_pkg::*;
#(
  parameter int ADDR_W  = OCC_ADDR_W,
  parameter int DATA_W  = OCC_DATA_W,
  parameter int TIMEOUT = OCC_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic              ce_rom_Occ_o,
  output logic [ADDR_W-1:0] addr_rom_Occ_o,
  input  logic [DATA_W-1:0] data_Occ_i,
  input  logic              data_valid,
  output logic              busy_o
);

  occ_state_e           state_r;
  logic                 owner_r;
  logic                 last_r;
  logic [OCC_CNT_W-1:0] cnt_r;
  logic                 gnt0_r, gnt1_r;
  logic                 rvalid0_r, rvalid1_r;
  logic                 err0_r, err1_r;
  logic [DATA_W-1:0]    rdata0_r, rdata1_r;
  logic                 ce_r;
  logic [ADDR_W-1:0]    addr_r;
  logic                 busy_r;

  logic                 pick_valid_s;
  logic                 pick_win_s;
  logic [OCC_CNT_W-1:0] cnt_next_s;
  logic                 timeout_s;
  logic                 resp_s;
  logic                 resp_err_s;
  logic [DATA_W-1:0]    resp_data_s;

  rr_pick2 u_pick (
    .req0  (req0_i),
    .req1  (req1_i),
    .last  (last_r),
    .valid (pick_valid_s),
    .win   (pick_win_s)
  );

  // response qualification; a data_valid on the timeout cycle wins over the error
  always_comb begin
    cnt_next_s = cnt_inc(cnt_r);
    timeout_s  = (cnt_next_s == OCC_CNT_W'(TIMEOUT));
    resp_s     = data_valid | timeout_s;
    resp_err_s = ~data_valid;
    if (data_valid) begin
      resp_data_s = data_Occ_i;
    end else begin
      resp_data_s = {DATA_W{1'b0}};
    end
  end

  // arbitration FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      cnt_r     <= {OCC_CNT_W{1'b0}};
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      err0_r    <= 1'b0;
      err1_r    <= 1'b0;
      rdata0_r  <= {DATA_W{1'b0}};
      rdata1_r  <= {DATA_W{1'b0}};
      ce_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      err0_r    <= 1'b0;
      err1_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            owner_r <= pick_win_s;
            gnt0_r  <= ~pick_win_s;
            gnt1_r  <= pick_win_s;
            addr_r  <= pick_win_s ? addr1_i : addr0_i;
            ce_r    <= 1'b1;
            cnt_r   <= {OCC_CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resp_s) begin
            if (owner_r) begin
              rdata1_r  <= resp_data_s;
              rvalid1_r <= 1'b1;
              err1_r    <= resp_err_s;
            end else begin
              rdata0_r  <= resp_data_s;
              rvalid0_r <= 1'b1;
              err0_r    <= resp_err_s;
            end
            last_r  <= owner_r;
            ce_r    <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        default: begin
          ce_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt0_o         = gnt0_r;
  assign gnt1_o         = gnt1_r;
  assign rvalid0_o      = rvalid0_r;
  assign rvalid1_o      = rvalid1_r;
  assign err0_o         = err0_r;
  assign err1_o         = err1_r;
  assign rdata0_o       = rdata0_r;
  assign rdata1_o       = rdata1_r;
  assign ce_rom_Occ_o   = ce_r;
  assign addr_rom_Occ_o = addr_r;
  assign busy_o         = busy_r;

endmodule
